// File: rtl/multi_channel_counter.sv
// Bank of NUM_CH up/down counters, each with a programmable terminal value,
// parallel load and wrap/saturate handling. Cascade mode forms a ripple chain.
module multi_channel_counter #(
    parameter int CNT_WIDTH = 8,
    parameter int NUM_CH    = 4,
    parameter int CASCADE   = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             en_i,
    input  logic [NUM_CH-1:0]             dir_i,
    input  logic [NUM_CH-1:0]             mode_i,
    input  logic [NUM_CH-1:0]             load_i,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   load_val_i,
    input  logic [NUM_CH*CNT_WIDTH-1:0]   end_val_i,
    output logic [NUM_CH*CNT_WIDTH-1:0]   cnt_o,
    output logic [NUM_CH-1:0]             end_o,
    output logic [NUM_CH-1:0]             sat_o
);

    logic [NUM_CH*CNT_WIDTH-1:0] r_cnt;
    logic [NUM_CH-1:0]           w_term;
    logic [NUM_CH-1:0]           w_eff_en;
    logic [NUM_CH-1:0]           w_end;

    // Single loop so the cascade enable ripples from channel 0 upward in order.
    always_comb begin
        w_term   = '0;
        w_eff_en = '0;
        w_end    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (dir_i[k])
                w_term[k] = (r_cnt[k*CNT_WIDTH +: CNT_WIDTH] == '0);
            else
                w_term[k] = (r_cnt[k*CNT_WIDTH +: CNT_WIDTH] >= end_val_i[k*CNT_WIDTH +: CNT_WIDTH]);

            if (k == 0 || CASCADE == 0)
                w_eff_en[k] = en_i[k];
            else
                w_eff_en[k] = en_i[k] & w_end[k-1];

            w_end[k] = w_eff_en[k] & w_term[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (load_i[k]) begin
                    r_cnt[k*CNT_WIDTH +: CNT_WIDTH] <= load_val_i[k*CNT_WIDTH +: CNT_WIDTH];
                end else if (w_eff_en[k]) begin
                    if (w_term[k]) begin
                        // Saturate mode parks on the terminal; wrap restarts the sequence.
                        if (!mode_i[k])
                            r_cnt[k*CNT_WIDTH +: CNT_WIDTH] <= dir_i[k] ? end_val_i[k*CNT_WIDTH +: CNT_WIDTH]
                                                                         : '0;
                    end else if (dir_i[k]) begin
                        r_cnt[k*CNT_WIDTH +: CNT_WIDTH] <= r_cnt[k*CNT_WIDTH +: CNT_WIDTH] - CNT_WIDTH'(1);
                    end else begin
                        r_cnt[k*CNT_WIDTH +: CNT_WIDTH] <= r_cnt[k*CNT_WIDTH +: CNT_WIDTH] + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    assign cnt_o = r_cnt;
    assign end_o = w_end;
    assign sat_o = mode_i & w_term;

endmodule

// File: doc/multi_channel_counter.md
# multi_channel_counter

Parametrised, multi-channel successor to the single-channel terminal counter. Each channel counts up or down between 0 and a runtime-programmable terminal value, supports a parallel load, and either wraps or saturates at the terminal. An optional cascade mode chains channels into a wide ripple counter, with each channel enabled by the terminal pulse of the channel below. It sits beside the existing timing and sequencing logic as the common counter primitive for timers, beat counters and prescalers.

## Interface
- CNT_WIDTH, 8, width of each channel's counter.
- NUM_CH, 4, number of independent channels (≥1).
- CASCADE, 0; when 1, channel k>0 advances only when channel k-1 asserts its terminal pulse.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en_i  in  NUM_CH  per-channel count request.
- dir_i  in  NUM_CH  per-channel direction: 0 = up, 1 = down.
- mode_i  in  NUM_CH  per-channel terminal behaviour: 0 = wrap, 1 = saturate.
- load_i  in  NUM_CH  per-channel synchronous load strobe.
- load_val_i  in  NUM_CH*CNT_WIDTH  load values; channel k uses bits [k*CNT_WIDTH +: CNT_WIDTH].
- end_val_i  in  NUM_CH*CNT_WIDTH  terminal values, same packing; sampled every cycle, not registered.
- cnt_o  out  NUM_CH*CNT_WIDTH  current counts, same packing; registered.
- end_o  out  NUM_CH  terminal pulse, combinational.
- sat_o  out  NUM_CH  channel is parked at its terminal in saturate mode, combinational.

## Operation
- Effective enable: eff_en[0] = en_i[0]. For k>0: eff_en[k] = en_i[k] when CASCADE=0; en_i[k] & end_o[k-1] when CASCADE=1.
- Terminal condition term[k]:
  - up: cnt ≥ end_val.
  - down: cnt == 0.
- end_o[k] = eff_en[k] & term[k].
- sat_o[k] = mode_i[k] & term[k], independent of enable.
- Per-channel next state, in priority order:
  1. rst: cnt ← 0.
  2. load_i: cnt ← load_val; load wins over counting and over terminal handling in the same cycle.
  3. eff_en & term & wrap:
     - up: cnt ← 0.
     - down: cnt ← end_val.
  4. eff_en & term & saturate: hold.
  5. eff_en & !term: cnt ← cnt+1 (up) or cnt−1 (down), modulo 2^CNT_WIDTH.
  6. otherwise: hold.
- Up count sequence is 0..end_val, so the period is end_val+1. Down count sequence is end_val..0.
- A load or end_val change that leaves cnt > end_val while counting up:
  - wrap mode: the next enabled cycle wraps to 0.
  - saturate mode: hold.
- end_val = 0, up: end_o equals eff_en every cycle and cnt stays 0. Down behaves the same way.
- Direction or mode may change any cycle and takes effect immediately on term, end_o and the next-state decision.
- Cascade chain is combinational from end_o[0] to end_o[NUM_CH-1]; there is no pipelining. NUM_CH·CNT_WIDTH bits must meet clk timing.

## Timing
- Reset: cnt_o = 0 on all channels from the first edge with rst high.
  - While in reset, end_o[k] and sat_o[k] still follow their combinational definitions.
  - Because cnt = 0, a down channel shows term=1.
- Count latency: en_i at edge n produces cnt_o updated after edge n. end_o is valid in the same cycle as the terminal count value.
- Load latency: one cycle. load_val appears on cnt_o after the edge, and end_o in the load cycle still reflects the pre-load cnt.
- Reset asserted mid-count clears the channel on that edge. Pending loads and enables are discarded.
- Channels are fully independent except through the cascade enable.

## Test plan
- Up/wrap: CNT_WIDTH=8, end_val=4, en held high, ch0.
  - Required: cnt_o 0,1,2,3,4,0,1…
  - Required: end_o high exactly in the cycles where cnt=4.
- Down/saturate: load 3, dir=1, mode=1, en held high.
  - Required: cnt 3,2,1,0,0,0…
  - Required: sat_o high from the cnt=0 cycle onward; end_o high every enabled cycle at 0.
- Load priority: at cnt=4 with end_val=4, assert load=9 and en together.
  - Required: next cnt=9, not 0.
  - Next enabled cycle (wrap, up, 9 ≥ 4): required cnt=0.
- Cascade: CASCADE=1, NUM_CH=2, end_val=2 on both channels, en_i=2'b11.
  - Required: ch1 increments once per 3 cycles.
  - Required: {ch1,ch0} reaches (2,2) at cycle 8, and end_o[1] pulses only in that cycle.
- Reset mid-operation: counts at 5/7/1/3, assert rst for one cycle together with load_i.
  - Required: all cnt_o = 0 after the edge; load ignored.
- Modulo edge: end_val=255, up, wrap.
  - Required: 254→255→0, with end_o at 255.
  - Down from load 0 in wrap mode with end_val=255: required 0→255.
